// File: rtl/rtc_bus_driver.sv
`default_nettype none
// ============================================================================
// Module   : rtc_bus_driver
// Brief    : Turns one RTC register request into a multiplexed address/data
//            bus cycle (address phase, gap, data phase) with a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_bus_driver #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       W_R,
    input  logic [7:0] direccion,
    input  logic [7:0] dato_escribir,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       a_d,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] dato_leido,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] c_ld_setup = 8'(T_SETUP - 1);
    localparam logic [7:0] c_ld_pulse = 8'(T_PULSE - 1);
    localparam logic [7:0] c_ld_hold  = 8'(T_HOLD - 1);
    localparam logic [7:0] c_ld_gap   = 8'(T_GAP - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_A_SETUP  = 4'd1,
        S_A_STROBE = 4'd2,
        S_A_HOLD   = 4'd3,
        S_GAP      = 4'd4,
        S_D_SETUP  = 4'd5,
        S_D_STROBE = 4'd6,
        S_D_HOLD   = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       r_wr;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic       w_wr_next;
    logic [7:0] w_addr_next;
    logic [7:0] w_data_next;
    logic       w_last;
    logic       w_accept;

    logic [7:0] w_ad_out;
    logic       w_ad_oe;
    logic       w_cs_n;
    logic       w_a_d;
    logic       w_wr_n;
    logic       w_rd_n;
    logic       w_busy;
    logic       w_done;

    assign w_last      = (r_cnt == 8'd0);
    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_wr_next   = w_accept ? W_R           : r_wr;
    assign w_addr_next = w_accept ? direccion     : r_addr;
    assign w_data_next = w_accept ? dato_escribir : r_data;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt - 8'd1;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = 8'd0;
                if (start) begin
                    w_state_next = S_A_SETUP;
                    w_cnt_next   = c_ld_setup;
                end
            end
            S_A_SETUP:  if (w_last) begin w_state_next = S_A_STROBE; w_cnt_next = c_ld_pulse; end
            S_A_STROBE: if (w_last) begin w_state_next = S_A_HOLD;   w_cnt_next = c_ld_hold;  end
            S_A_HOLD:   if (w_last) begin w_state_next = S_GAP;      w_cnt_next = c_ld_gap;   end
            S_GAP:      if (w_last) begin w_state_next = S_D_SETUP;  w_cnt_next = c_ld_setup; end
            S_D_SETUP:  if (w_last) begin w_state_next = S_D_STROBE; w_cnt_next = c_ld_pulse; end
            S_D_STROBE: if (w_last) begin w_state_next = S_D_HOLD;   w_cnt_next = c_ld_hold;  end
            S_D_HOLD:   if (w_last) begin w_state_next = S_DONE;     w_cnt_next = 8'd0;       end
            S_DONE: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 8'd0;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up
    // with the state register itself.
    always_comb begin
        w_ad_out = 8'd0;
        w_ad_oe  = 1'b0;
        w_cs_n   = 1'b1;
        w_a_d    = 1'b0;
        w_wr_n   = 1'b1;
        w_rd_n   = 1'b1;
        w_busy   = 1'b1;
        w_done   = 1'b0;
        case (w_state_next)
            S_IDLE: w_busy = 1'b0;
            S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
                w_cs_n   = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = w_addr_next;
                w_wr_n   = (w_state_next != S_A_STROBE);
            end
            S_GAP: w_a_d = 1'b1;
            S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
                w_cs_n   = 1'b0;
                w_a_d    = 1'b1;
                w_ad_oe  = w_wr_next;
                w_ad_out = w_wr_next ? w_data_next : 8'd0;
                if (w_state_next == S_D_STROBE) begin
                    w_wr_n = ~w_wr_next;
                    w_rd_n = w_wr_next;
                end
            end
            S_DONE: w_done = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_wr       <= 1'b0;
            r_addr     <= 8'd0;
            r_data     <= 8'd0;
            ad_out     <= 8'd0;
            ad_oe      <= 1'b0;
            cs_n       <= 1'b1;
            a_d        <= 1'b0;
            wr_n       <= 1'b1;
            rd_n       <= 1'b1;
            dato_leido <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_wr    <= w_wr_next;
            r_addr  <= w_addr_next;
            r_data  <= w_data_next;
            ad_out  <= w_ad_out;
            ad_oe   <= w_ad_oe;
            cs_n    <= w_cs_n;
            a_d     <= w_a_d;
            wr_n    <= w_wr_n;
            rd_n    <= w_rd_n;
            busy    <= w_busy;
            done    <= w_done;
            if ((r_state == S_D_STROBE) && w_last && !r_wr) begin
                dato_leido <= ad_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_bus_driver
// Brief    : Self-checking bench for rtc_bus_driver (default and minimum timing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_driver;

    logic       clk;
    logic       reset;
    logic       start_a;
    logic       start_b;
    logic       W_R;
    logic [7:0] direccion;
    logic [7:0] dato_escribir;
    logic [7:0] ad_in;

    logic [7:0] ad_out_a, dato_leido_a;
    logic       ad_oe_a, cs_n_a, a_d_a, wr_n_a, rd_n_a, busy_a, done_a;
    logic [7:0] ad_out_b, dato_leido_b;
    logic       ad_oe_b, cs_n_b, a_d_b, wr_n_b, rd_n_b, busy_b, done_b;

    int n_checks = 0;
    int n_fail   = 0;

    rtc_bus_driver dut_a (
        .clk(clk), .reset(reset), .start(start_a), .W_R(W_R),
        .direccion(direccion), .dato_escribir(dato_escribir), .ad_in(ad_in),
        .ad_out(ad_out_a), .ad_oe(ad_oe_a), .cs_n(cs_n_a), .a_d(a_d_a),
        .wr_n(wr_n_a), .rd_n(rd_n_a), .dato_leido(dato_leido_a),
        .busy(busy_a), .done(done_a)
    );

    rtc_bus_driver #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .W_R(W_R),
        .direccion(direccion), .dato_escribir(dato_escribir), .ad_in(ad_in),
        .ad_out(ad_out_b), .ad_oe(ad_oe_b), .cs_n(cs_n_b), .a_d(a_d_b),
        .wr_n(wr_n_b), .rd_n(rd_n_b), .dato_leido(dato_leido_b),
        .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] rdata;
        logic [7:0] exp_leido;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // {ad_oe, cs_n, a_d, wr_n, rd_n, busy, done, ad_out-while-driven}
    function automatic logic [14:0] bundle(input bit sel);
        if (sel)
            return {ad_oe_b, cs_n_b, a_d_b, wr_n_b, rd_n_b, busy_b, done_b, ad_oe_b ? ad_out_b : 8'h00};
        return {ad_oe_a, cs_n_a, a_d_a, wr_n_a, rd_n_a, busy_a, done_a, ad_oe_a ? ad_out_a : 8'h00};
    endfunction

    // Expected bus state in busy cycle k (k=0: idle), derived from phase lengths.
    function automatic logic [14:0] model(input int k, input int s, input int p, input int h,
                                          input int g, input bit wr, input logic [7:0] addr,
                                          input logic [7:0] data);
        int l = s + p + h;
        int j;
        logic oe = 0, cs = 1, ad = 0, wn = 1, rn = 1, dn = 0;
        logic [7:0] ao = 8'h00;
        if (k >= 1 && k <= l) begin
            cs = 0; oe = 1; ao = addr;
            if (k > s && k <= s + p) wn = 0;
        end else if (k > l && k <= l + g) begin
            ad = 1;
        end else if (k > l + g && k <= 2 * l + g) begin
            j = k - l - g;
            cs = 0; ad = 1; oe = wr; ao = wr ? data : 8'h00;
            if (j > s && j <= s + p) begin
                if (wr) wn = 0; else rn = 0;
            end
        end else if (k == 2 * l + g + 1) begin
            dn = 1;
        end
        return {oe, cs, ad, wn, rn, (k != 0), dn, ao};
    endfunction

    // junk: 0 quiet inputs, 1 random inputs while busy, 2 one stray start (addr 23) at cycle 5
    task automatic run_txn(input bit sel, input bit wr, input logic [7:0] addr,
                           input logic [7:0] data, input logic [7:0] rdata,
                           input logic [7:0] exp_rd, input int junk, input string tag);
        int s, p, h, g, l, n;
        if (sel) begin s = 1; p = 1; h = 1; g = 1; end
        else begin s = 2; p = 4; h = 2; g = 2; end
        l = s + p + h;
        n = 2 * l + g;
        W_R = wr; direccion = addr; dato_escribir = data;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        for (int k = 1; k <= n + 1; k++) begin
            if (junk == 1) begin
                W_R = 1'($urandom); direccion = 8'($urandom); dato_escribir = 8'($urandom);
                if (sel) start_b = 1'($urandom); else start_a = 1'($urandom);
            end else if (junk == 2) begin
                start_a = (k == 5); start_b = 1'b0;
                if (k == 5) direccion = 8'h23;
            end
            chk($sformatf("%s bus cyc%0d", tag, k), 32'(bundle(sel)),
                32'(model(k, s, p, h, g, wr, addr, data)));
            if (k == n + 1) begin
                chk($sformatf("%s dato_leido", tag), 32'(sel ? dato_leido_b : dato_leido_a), 32'(exp_rd));
                start_a = 1'b0; start_b = 1'b0;
            end
            ad_in = (!wr && k == l + g + s + p) ? rdata : 8'($urandom);
            @(posedge clk); #1;
        end
        chk($sformatf("%s back to idle", tag), 32'(bundle(sel)), 32'(model(0, s, p, h, g, wr, addr, data)));
    endtask

    vec_t vecs[5];
    logic [7:0] model_rd;
    int done_cyc[$];

    initial begin
        vecs[0] = '{1'b1, 8'h21, 8'h45, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 8'h22, 8'h00, 8'h59, 8'h59};
        vecs[2] = '{1'b1, 8'hA5, 8'h3C, 8'hEE, 8'h59};
        vecs[3] = '{1'b0, 8'hFF, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 8'hC3, 8'hC3};

        reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
        W_R = 1'b0; direccion = 8'h00; dato_escribir = 8'h00; ad_in = 8'h00;
        #22;
        chk("reset bus a", 32'(bundle(0)), 32'(model(0, 2, 4, 2, 2, 0, 0, 0)));
        chk("reset bus b", 32'(bundle(1)), 32'(model(0, 1, 1, 1, 1, 0, 0, 0)));
        chk("reset ad_out a", 32'(ad_out_a), 32'h0);
        chk("reset dato_leido a", 32'(dato_leido_a), 32'h0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("idle after release", 32'(bundle(0)), 32'(model(0, 2, 4, 2, 2, 0, 0, 0)));

        for (int i = 0; i < 5; i++)
            run_txn(0, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].rdata,
                    vecs[i].exp_leido, 0, $sformatf("vec%0d", i));
        model_rd = vecs[4].exp_leido;

        run_txn(0, 1'b1, 8'h21, 8'h45, 8'h00, model_rd, 2, "busy_ignore");

        for (int i = 0; i < 12; i++) begin
            bit         wr    = 1'($urandom);
            logic [7:0] addr  = 8'($urandom);
            logic [7:0] data  = 8'($urandom);
            logic [7:0] rdata = 8'($urandom);
            if (!wr) model_rd = rdata;
            run_txn(0, wr, addr, data, rdata, model_rd, 1, $sformatf("rnd%0d", i));
        end

        run_txn(1, 1'b1, 8'h21, 8'h45, 8'h00, 8'h00, 0, "min_wr");
        run_txn(1, 1'b0, 8'h22, 8'h00, 8'h59, 8'h59, 0, "min_rd");

        // start held high: a new transaction starts in every idle cycle
        W_R = 1'b1; direccion = 8'h21; dato_escribir = 8'h45; start_a = 1'b1;
        for (int c = 1; c <= 62 && done_cyc.size() < 3; c++) begin
            @(posedge clk); #1;
            if (done_a) done_cyc.push_back(c);
        end
        start_a = 1'b0;
        chk("b2b done count", 32'(done_cyc.size()), 32'd3);
        if (done_cyc.size() == 3) begin
            chk("b2b first done", 32'(done_cyc[0]), 32'd19);
            chk("b2b gap1", 32'(done_cyc[1] - done_cyc[0]), 32'd20);
            chk("b2b gap2", 32'(done_cyc[2] - done_cyc[1]), 32'd20);
        end
        repeat (25) @(posedge clk);
        #1;
        chk("b2b idle", 32'(busy_a), 32'd0);

        run_txn(0, 1'b0, 8'h30, 8'h00, 8'h5A, 8'h5A, 0, "pre_reset_rd");
        W_R = 1'b1; direccion = 8'h40; dato_escribir = 8'h77; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midop in strobe", 32'({cs_n_a, wr_n_a}), 32'b00);
        #2 reset = 1'b0;
        #1;
        chk("midop async strobes", 32'({cs_n_a, wr_n_a, ad_oe_a, busy_a}), 32'b1100);
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post reset idle", 32'(bundle(0)), 32'(model(0, 2, 4, 2, 2, 0, 0, 0)));
        chk("post reset dato_leido", 32'(dato_leido_a), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("post reset stays idle", 32'({busy_a, done_a, cs_n_a}), 32'b001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
